// File: rtl/two_to_one_mux.sv
// two_to_one_mux
// Registered (or optionally combinational) WIDTH-bit 2:1 selector used for
// operand and writeback source selection in the pipelined MIPS datapath.
// The select word is treated as a boolean: zero picks a, any nonzero value picks b.
// Handshake: none. Data is captured on every rising clock edge. There is no
// valid/ready pair, no enable and no hold.
module two_to_one_mux #(
    parameter int WIDTH   = 16,
    parameter bit REG_OUT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] out
);

    logic             sel;
    logic [WIDTH-1:0] nxt;

    // Select decode and full-width pass-through of the chosen source
    always_comb begin
        sel = |s;
        nxt = sel ? b : a;
    end

    generate
        if (REG_OUT) begin : g_reg
            logic [WIDTH-1:0] out_d;
            logic [WIDTH-1:0] out_q;

            // Next value of the output register is the selection itself
            always_comb begin
                out_d = nxt;
            end

            // Output register: cleared asynchronously, reloaded every edge
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    out_q <= '0;
                end else begin
                    out_q <= out_d;
                end
            end

            assign out = out_q;
        end else begin : g_comb
            // Clock and reset have no role in the combinational variant
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign out = nxt;
        end
    endgenerate

endmodule

// File: tb/tb_two_to_one_mux.sv
// Directed self-checking bench for two_to_one_mux, covering the registered
// default build and a combinational (REG_OUT=0) build.
module tb_two_to_one_mux;

    localparam int W = 16;

    logic         clk;
    logic         rst;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] s;
    logic [W-1:0] out;

    logic         clk_c;
    logic         rst_c;
    logic [W-1:0] a_c;
    logic [W-1:0] b_c;
    logic [W-1:0] s_c;
    logic [W-1:0] out_c;

    int tests_run    = 0;
    int tests_failed = 0;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    two_to_one_mux #(.WIDTH(W), .REG_OUT(1'b1)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .s(s), .out(out)
    );

    two_to_one_mux #(.WIDTH(W), .REG_OUT(1'b0)) dut_comb (
        .clk(clk_c), .rst(rst_c), .a(a_c), .b(b_c), .s(s_c), .out(out_c)
    );

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Apply inputs on the falling edge, away from the capturing edge
    task automatic drive(input logic [W-1:0] va, input logic [W-1:0] vb, input logic [W-1:0] vs);
        @(negedge clk);
        a = va;
        b = vb;
        s = vs;
    endtask

    // Advance past the next rising edge and settle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_check(input string tag, input logic [W-1:0] va, input logic [W-1:0] vb,
                               input logic [W-1:0] vs, input logic [W-1:0] exp);
        drive(va, vb, vs);
        #1;
        tick();
        check(tag, out, exp);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Reset with all-ones data and a nonzero select
        rst = 1'b1;
        a   = 16'hFFFF;
        b   = 16'hFFFF;
        s   = 16'h0001;
        clk_c = 1'b0;
        rst_c = 1'b0;
        a_c   = '0;
        b_c   = '0;
        s_c   = '0;
        #1;
        check("reset_immediate", out, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset_hold", out, 16'h0000);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_release_between_edges", out, 16'h0000);
        tick();
        check("first_load_after_reset", out, 16'hFFFF);

        // Select a (s = 0), back-to-back
        apply_check("sel_a_0", 16'd10, 16'd0, 16'd0, 16'd10);
        apply_check("sel_a_1", 16'd0,  16'd1, 16'd0, 16'd0);
        apply_check("sel_a_2", 16'd13, 16'd0, 16'd0, 16'd13);
        apply_check("sel_a_3", 16'd12, 16'd1, 16'd0, 16'd12);

        // Select b (s = 1)
        apply_check("sel_b_0", 16'd10, 16'd0, 16'd1, 16'd0);
        apply_check("sel_b_1", 16'd13, 16'd1, 16'd1, 16'd1);
        apply_check("sel_b_2", 16'd12, 16'd0, 16'd1, 16'd0);
        apply_check("sel_b_3", 16'd10, 16'd1, 16'd1, 16'd1);

        // Nonzero select words of differing bit positions
        apply_check("sel_word_8000", 16'h1234, 16'hABCD, 16'h8000, 16'hABCD);
        apply_check("sel_word_0100", 16'h1234, 16'hABCD, 16'h0100, 16'hABCD);
        apply_check("sel_word_ffff", 16'h1234, 16'hABCD, 16'hFFFF, 16'hABCD);
        apply_check("sel_word_zero", 16'h1234, 16'hABCD, 16'h0000, 16'h1234);

        // Input change between edges must not reach the output early
        drive(16'h5A5A, 16'hA5A5, 16'h0001);
        #1;
        check("no_early_propagation", out, 16'h1234);
        tick();
        check("simultaneous_change", out, 16'hA5A5);

        // Mid-stream reset pulse between edges
        apply_check("stream_before_reset", 16'd5, 16'd7, 16'd1, 16'd7);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("mid_reset_immediate", out, 16'h0000);
        tick();
        check("mid_reset_through_edge", out, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_reset_released", out, 16'h0000);
        tick();
        check("mid_reset_recover", out, 16'd7);

        // Combinational build: no clock activity on its clk
        a_c = 16'd10;
        b_c = 16'd3;
        s_c = 16'd0;
        #1;
        check("comb_s0", out_c, 16'd10);
        s_c = 16'd1;
        #1;
        check("comb_s1", out_c, 16'd3);
        s_c = 16'd0;
        #1;
        check("comb_s0_again", out_c, 16'd10);
        rst_c = 1'b1;
        #1;
        check("comb_rst_ignored", out_c, 16'd10);
        s_c = 16'h4000;
        #1;
        check("comb_rst_sel_b", out_c, 16'd3);
        rst_c = 1'b0;

        // ---------------- report ----------------
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Watchdog: guarantees termination even if a wait never completes
    initial begin
        #100000;
        tests_failed++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/two_to_one_mux.md
# two_to_one_mux

Registered 16-bit 2:1 selector for the pipelined MIPS datapath (operand/writeback source selection). Each rising clock edge captures `a` or `b` on `out` according to `s`. Output is cleared by an asynchronous active-high reset.

## Interface

Parameters:
- `WIDTH`, default 16: data width of `a`, `b`, `s` and `out`.
- `REG_OUT`, default 1:
  - 1: output is registered, 1-cycle latency.
  - 0: output is purely combinational, and `clk` and `rst` are unused.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  asynchronous, active-high reset.
- `a`  input  WIDTH  data input 0, selected when `s` is zero.
- `b`  input  WIDTH  data input 1, selected when `s` is nonzero.
- `s`  input  WIDTH  select word; only zero vs nonzero is significant.
- `out`  output  WIDTH  selected data.

## Operation

- Select decode: `sel = |s`, the reduction OR of all WIDTH bits of `s`.
  - `s == 0` selects `a`.
  - Any nonzero `s` (e.g. 16'h0001, 16'h8000, 16'hFFFF) selects `b`.
  - X/Z on `s`: no defined result is required; the bench must not drive it.
- Next value: `nxt = sel ? b : a`. This is a bitwise full-width pass-through with no arithmetic, truncation or extension.
- With `REG_OUT=1`:
  - `out` loads `nxt` on every rising edge of `clk` while `rst` is low.
  - There is no enable and no hold; the output updates every cycle.
- With `REG_OUT=0`: `out = nxt` continuously.
- Reset (`REG_OUT=1`):
  - `rst` high forces `out` to 0 immediately, without waiting for a clock edge.
  - `out` stays 0 while `rst` is high, regardless of `a`, `b`, `s` or clock activity.
- The block has no internal state other than the `out` register and no state machine.

## Timing

- Reset value of `out`: all zeros.
- Latency with `REG_OUT=1`:
  - Inputs sampled at rising edge N appear on `out` immediately after edge N.
  - They remain there until edge N+1.
- Input changes between edges have no effect on `out` until the next rising edge. There is no glitch propagation.
- Reset deassertion:
  - The first load occurs at the first rising edge at which `rst` is sampled low.
  - `rst` falling between edges leaves `out` at 0 until that edge.
- Reset mid-stream: asserting `rst` at any time discards the held value. `out` becomes 0 within the same time step.
- Simultaneous change of `a`, `b` and `s` before an edge: the edge captures the new `s` applied to the new `a`/`b`, with no mixing of old and new values.
- Back-to-back: a new selection is captured every cycle, giving full throughput.

## Test plan

- Reset: assert `rst` with a=16'hFFFF, b=16'hFFFF, s=1 and clock toggling. Required: `out`=0 immediately and throughout reset. First edge after release gives `out`=16'hFFFF.
- Select a: apply these pairs with s=0 on consecutive cycles:
  - (a=10, b=0) → 10
  - (a=0, b=1) → 0
  - (a=13, b=0) → 13
  - (a=12, b=1) → 12
  - Each value must appear one edge after it is applied.
- Select b: apply these pairs with s=1:
  - (a=10, b=0) → 0
  - (a=13, b=1) → 1
  - (a=12, b=0) → 0
  - (a=10, b=1) → 1
- Nonzero select word: with a=16'h1234, b=16'hABCD, apply s=16'h8000 → 16'hABCD, then s=16'h0100 → 16'hABCD, then s=0 → 16'h1234.
- Mid-operation reset: streaming a=5, b=7, s=1 gives `out`=7. Pulse `rst` between edges. Required: `out` drops to 0 immediately, stays 0 through the next edge if `rst` is still high, then returns to 7 on the first edge after release.
- Combinational variant (`REG_OUT=0`): a=10, b=3; toggling s 0→1→0 gives `out` 10→3→10 with no clock. `rst` has no effect.
